// File: rtl/sqrt_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module : sqrt_iter_ctrl
// Desc   : Sequencer for an iterative integer square-root datapath, one
//          radicand bit-pair per cycle. Optional macro: SQRT_ZERO_BYPASS_EN.
// Rev    : 1.0
// ============================================================================
module sqrt_iter_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  input  logic             zero_i,
  output logic             wr_input_o,
  output logic             clr_acc_o,
  output logic             en_step_o,
  output logic [CNT_W-1:0] iter_idx_o,
  output logic             wr_result_o,
  output logic             busy_o
);

  localparam int               ITER_N   = DATA_WIDTH / 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER_N - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_LOAD = 3'b001,
    S_ITER = 3'b011,
    S_WB   = 3'b010,
    S_DONE = 3'b110
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_zero_skip;

`ifdef SQRT_ZERO_BYPASS_EN
  assign w_zero_skip = zero_i;
`else
  logic w_unused_zero;
  assign w_unused_zero = zero_i;
  assign w_zero_skip   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    wr_input_o  = 1'b0;
    clr_acc_o   = 1'b0;
    en_step_o   = 1'b0;
    iter_idx_o  = '0;
    wr_result_o = 1'b0;
    busy_o      = 1'b0;

    case (r_state)
      S_IDLE: begin
        in_ready_o = 1'b1;
        wr_input_o = in_valid_i;
        if (in_valid_i) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy_o      = 1'b1;
        clr_acc_o   = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = w_zero_skip ? S_WB : S_ITER;
      end
      S_ITER: begin
        busy_o     = 1'b1;
        en_step_o  = 1'b1;
        // MSB bit-pair is retired first
        iter_idx_o = LAST_CNT - r_cnt;
        if (r_cnt == LAST_CNT) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_WB;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_WB: begin
        busy_o      = 1'b1;
        wr_result_o = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        if (out_ready_i) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sqrt_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_sqrt_iter_ctrl
// Desc   : Directed self-checking bench for sqrt_iter_ctrl with a timeline model.
// Rev    : 1.0
// ============================================================================
module tb_sqrt_iter_ctrl;

  localparam int DATA_WIDTH = 16;
  localparam int CNT_W      = 3;
  localparam int ITER_N     = DATA_WIDTH / 2;
`ifdef SQRT_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid_i = 1'b0;
  logic             out_ready_i = 1'b0;
  logic             zero_i = 1'b0;
  logic             in_ready_o;
  logic             out_valid_o;
  logic             wr_input_o;
  logic             clr_acc_o;
  logic             en_step_o;
  logic [CNT_W-1:0] iter_idx_o;
  logic             wr_result_o;
  logic             busy_o;

  sqrt_iter_ctrl #(.DATA_WIDTH(DATA_WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .zero_i     (zero_i),
    .wr_input_o (wr_input_o),
    .clr_acc_o  (clr_acc_o),
    .en_step_o  (en_step_o),
    .iter_idx_o (iter_idx_o),
    .wr_result_o(wr_result_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model: m_age counts edges since the accepting edge (-1 = idle).
  // Age 1 clears, ages 2..ITER_N+1 step, wb_age writes back, later ages wait.
  int m_age = -1;
  bit m_byp = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age <= -1;
      m_byp <= 1'b0;
    end else if (m_age < 0) begin
      if (in_valid_i) begin
        m_age <= 1;
        m_byp <= 1'b0;
      end
    end else if (m_age == 1) begin
      m_byp <= BYP && zero_i;
      m_age <= 2;
    end else if (m_age > (m_byp ? 2 : ITER_N + 2)) begin
      if (out_ready_i) m_age <= -1;
    end else begin
      m_age <= m_age + 1;
    end
  end

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int en_total  = 0;
  int wr_total  = 0;
  int clr_total = 0;
  int ov_rise   = 0;
  int acc_n     = 0;
  int acc_edge [0:15];
  int idx_log  [0:255];
  bit prev_ov   = 1'b0;

  always @(negedge clk) begin
    if (en_step_o) begin
      idx_log[en_total % 256] <= int'(iter_idx_o);
      en_total <= en_total + 1;
    end
    if (wr_result_o) wr_total <= wr_total + 1;
    if (clr_acc_o) clr_total <= clr_total + 1;
    if (wr_input_o) begin
      acc_edge[acc_n % 16] <= edge_n + 1;
      acc_n <= acc_n + 1;
    end
    if (out_valid_o && !prev_ov) ov_rise <= ov_rise + 1;
    prev_ov <= out_valid_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    int               wb;
    logic             en;
    logic [CNT_W-1:0] idx;
    wb  = m_byp ? 2 : ITER_N + 2;
    en  = !m_byp && m_age >= 2 && m_age <= ITER_N + 1;
    idx = en ? CNT_W'(ITER_N - 1 - (m_age - 2)) : '0;
    check("m_in_ready",  32'(in_ready_o),  32'(m_age < 0));
    check("m_wr_input",  32'(wr_input_o),  32'(m_age < 0 && in_valid_i && rst_n));
    check("m_clr_acc",   32'(clr_acc_o),   32'(m_age == 1));
    check("m_en_step",   32'(en_step_o),   32'(en));
    check("m_iter_idx",  32'(iter_idx_o),  32'(idx));
    check("m_wr_result", 32'(wr_result_o), 32'(m_age == wb));
    check("m_out_valid", 32'(out_valid_o), 32'(m_age > wb));
    check("m_busy",      32'(busy_o),      32'(m_age > 0));
  endtask

  // One cycle: model compare on the falling edge, return just after the rising edge
  task automatic tick();
    @(negedge clk);
    cmp_model();
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input string tag, input int exp_lat, input int exp_en);
    int e0, w0, c0, n;
    e0 = en_total; w0 = wr_total; c0 = clr_total;
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    #1 check({tag, "_wr_input"}, 32'(wr_input_o), 32'd1);
    tick();
    in_valid_i = 1'b0;
    n = 0;
    while (!out_valid_o && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_en_cycles"}, 32'(en_total - e0), 32'(exp_en));
    check({tag, "_wr_result"}, 32'(wr_total - w0), 32'd1);
    check({tag, "_clr_acc"}, 32'(clr_total - c0), 32'd1);
    for (int k = 0; k < exp_en; k++)
      check({tag, "_idx_seq"}, 32'(idx_log[(e0 + k) % 256]), 32'(ITER_N - 1 - k));
    tick();
    check({tag, "_back_idle"}, 32'(in_ready_o), 32'd1);
    check({tag, "_ov_clear"}, 32'(out_valid_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w0, a0, ov0;

    // Reset state
    repeat (3) tick();
    check("rst_in_ready",  32'(in_ready_o),  32'd1);
    check("rst_busy",      32'(busy_o),      32'd0);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_iter_idx",  32'(iter_idx_o),  32'd0);
    rst_n = 1'b1;
    tick();

    // Single request: full 8-step sequence, out_valid after edge E10
    run_req("single", 10, 8);

    // Backpressure in DONE
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    tick();
    in_valid_i = 1'b0;
    n = 0;
    while (!out_valid_o && n < 30) begin
      tick();
      n++;
    end
    check("bp_latency", 32'(n), 32'd10);
    for (int i = 0; i < 5; i++) begin
      in_valid_i = (i % 2 == 0);
      #1;
      check("bp_out_valid", 32'(out_valid_o), 32'd1);
      check("bp_in_ready",  32'(in_ready_o),  32'd0);
      check("bp_wr_input",  32'(wr_input_o),  32'd0);
      tick();
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    tick();
    check("bp_release_idle", 32'(in_ready_o),  32'd1);
    check("bp_release_ov",   32'(out_valid_o), 32'd0);

    // Abort with asynchronous reset in ITER at cnt=4
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    repeat (5) tick();
    #1 check("abort_idx_before", 32'(iter_idx_o), 32'd3);
    w0 = wr_total;
    #1 rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready_o),  32'd1);
    check("abort_busy",     32'(busy_o),      32'd0);
    check("abort_en_step",  32'(en_step_o),   32'd0);
    check("abort_idx",      32'(iter_idx_o),  32'd0);
    check("abort_wr_res",   32'(wr_result_o), 32'd0);
    check("abort_ov",       32'(out_valid_o), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_no_wr", 32'(wr_total - w0), 32'd0);
    check("abort_idle",  32'(in_ready_o),    32'd1);
    run_req("post_abort", 10, 8);

    // Back-to-back with in_valid held high
    a0  = acc_n;
    ov0 = ov_rise;
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    n = 0;
    while (acc_n < a0 + 2 && n < 60) begin
      tick();
      n++;
    end
    in_valid_i = 1'b0;
    check("b2b_accepts", 32'(acc_n - a0), 32'd2);
    check("b2b_period",  32'(acc_edge[(a0 + 1) % 16] - acc_edge[a0 % 16]), 32'd12);
    repeat (14) tick();
    check("b2b_ov_pulses", 32'(ov_rise - ov0), 32'd2);
    check("b2b_idle",      32'(in_ready_o),    32'd1);

    // Zero radicand: bypass when enabled, normal sequence otherwise
    zero_i = 1'b1;
    run_req("zero", BYP ? 2 : 10, BYP ? 0 : 8);
    zero_i = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sqrt_iter_ctrl.md
Name: sqrt_iter_ctrl

Overview:
Sequencing controller for a multi-cycle iterative integer square-root datapath. It retires one radicand bit-pair per cycle.
- Accepts a radicand with a valid/ready handshake and drives the datapath strobes (load, clear, step, iteration index, result write).
- Presents the result with a valid/ready handshake.
- Sits between the requesting logic and the sqrt datapath; the datapath itself holds all data registers.

Parameters:
DATA_WIDTH, 16, radicand width in bits; must be even and >= 4. ITER_N = DATA_WIDTH/2 (localparam).
CNT_W, 3, iteration counter / index width; must satisfy 2**CNT_W >= ITER_N.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid_i  input  1  requester has a radicand on the datapath input bus
in_ready_o  output  1  controller can accept a radicand
out_valid_o  output  1  datapath result register holds a valid root
out_ready_i  input  1  consumer takes the result
zero_i  input  1  datapath flag: captured radicand == 0 (used only with the optional feature)
wr_input_o  output  1  datapath captures radicand this cycle
clr_acc_o  output  1  datapath clears root/remainder accumulators
en_step_o  output  1  datapath performs one iteration step
iter_idx_o  output  CNT_W  bit-pair index for the current step, MSB pair first
wr_result_o  output  1  datapath captures root into result register
busy_o  output  1  request in flight (state != IDLE)

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset:
  - State goes to IDLE and the counter clears to 0 immediately, independent of clk.
  - During and after reset: in_ready_o=1; all other outputs 0; iter_idx_o=0.
- State encoding (3 bits): IDLE=000, LOAD=001, ITER=011, WB=010, DONE=110. All outputs are Moore, except wr_input_o.
- IDLE:
  - in_ready_o=1.
  - wr_input_o = in_valid_i (combinational).
  - When in_valid_i=1 at the rising edge, go to LOAD; otherwise stay in IDLE.
- LOAD:
  - clr_acc_o=1; counter <= 0.
  - Next state is ITER.
- ITER:
  - en_step_o=1; iter_idx_o = ITER_N-1-cnt.
  - cnt increments each cycle.
  - When cnt == ITER_N-1, go to WB and clear cnt to 0.
  - en_step_o is high for exactly ITER_N consecutive cycles per request.
- WB:
  - wr_result_o=1 for exactly one cycle.
  - Next state is DONE.
- DONE:
  - out_valid_o=1, held stable until out_ready_i=1 at a rising edge, then go to IDLE.
  - No new radicand is accepted in DONE (in_ready_o=0), so back-to-back requests have one IDLE cycle between them.
- Latency:
  - Accepting edge E0 -> out_valid_o high after edge E0+ITER_N+2 (E10 for DATA_WIDTH=16).
  - Minimum request-to-request period is ITER_N+4 cycles.
- in_ready_o=0 in every state except IDLE. in_valid_i outside IDLE is ignored and never causes wr_input_o.
- out_ready_i outside DONE is ignored.
- busy_o=1 in LOAD, ITER, WB and DONE.
- Reset mid-operation (any state) aborts the request:
  - No wr_result_o or out_valid_o is produced.
  - On release, the controller is in IDLE with in_ready_o=1.
- Illegal state encodings: next state is IDLE; all outputs are 0 in that cycle.
- iter_idx_o is 0 in every state except ITER.
- Counter never exceeds ITER_N-1.

Optional Feature:
SQRT_ZERO_BYPASS_EN
- Defined:
  - In LOAD, if zero_i=1, go directly to WB and skip ITER entirely; en_step_o never asserts.
  - The datapath writes the cleared accumulator (root 0).
  - out_valid_o is high after edge E0+2.
- Not defined: zero_i is ignored and every request takes the full ITER_N steps.

Test Plan:
- Reset: rst_n low asynchronously mid-cycle -> in_ready_o=1; out_valid_o, en_step_o, wr_result_o, busy_o all 0; iter_idx_o=0 without waiting for a clock edge.
- Single request, DATA_WIDTH=16: in_valid_i=1 for one cycle with out_ready_i=1 -> wr_input_o=1 in the accept cycle, clr_acc_o=1 for 1 cycle, en_step_o=1 for exactly 8 cycles with iter_idx_o 7,6,...,0, wr_result_o=1 for 1 cycle, out_valid_o rises after edge E10, then IDLE.
- Backpressure: out_ready_i=0 for 5 cycles in DONE -> out_valid_o stays 1, in_ready_o stays 0, in_valid_i pulses ignored (no wr_input_o); out_ready_i=1 -> IDLE on the next edge.
- Abort: rst_n asserted while in ITER at cnt=4 -> immediate IDLE, cnt=0; no wr_result_o; a fresh request afterwards completes with the normal 10-edge latency.
- Back-to-back: in_valid_i held high across two requests with out_ready_i=1 -> second accept edge is exactly 12 cycles after the first; two out_valid_o pulses.
- With SQRT_ZERO_BYPASS_EN and zero_i=1 in LOAD -> en_step_o never high, wr_result_o at the cycle after LOAD, out_valid_o after E2. Without the macro, same stimulus -> normal 8-step sequence.
